// File: rtl/temp_poller_pkg.sv
// Shared types and constants for the ADT7301-class temperature poller.
package temp_poller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } poll_state_t;

    localparam int FRAME_BITS   = 16;
    localparam int DATA_BITS    = 14;
    localparam int LSB_PER_DEGC = 32;   // one LSB is 1/32 degC

    // Sensor marks a conversion word with 00 in the two bits above the data field.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] w);
        return w[FRAME_BITS-1:DATA_BITS] == '0;
    endfunction

    function automatic logic [FRAME_BITS-1:0] sign_extend_data(input logic [FRAME_BITS-1:0] w);
        return {{(FRAME_BITS-DATA_BITS){w[DATA_BITS-1]}}, w[DATA_BITS-1:0]};
    endfunction

endpackage

// File: rtl/temp_spi_shift.sv
// SPI mode-3 bit engine: generates SCLK and shifts in one 16-bit frame MSB first.
module temp_spi_shift
    import temp_poller_pkg::*;
#(
    parameter int CLK_DIV = 5
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  sdi,
    output logic                  sclk,
    output logic                  done,
    output logic [FRAME_BITS-1:0] word
);

    localparam int              BIT_W    = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);

    logic                  active_reg;
    logic                  sclk_reg;
    logic [7:0]            phase_reg;
    logic [BIT_W-1:0]      bit_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  sdi_reg;
    logic                  last_phase;

    assign last_phase = (phase_reg == DIV_LAST);
    // High during the final cycle of the last high half-period so the caller moves on without a gap.
    assign done = active_reg && sclk_reg && last_phase && (bit_reg == BIT_LAST);
    assign sclk = sclk_reg;
    assign word = shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            sclk_reg   <= 1'b1;
            phase_reg  <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            sdi_reg    <= 1'b0;
        end else begin
            sdi_reg <= sdi;
            if (go && !active_reg) begin
                active_reg <= 1'b1;
                sclk_reg   <= 1'b0;
                phase_reg  <= '0;
                bit_reg    <= '0;
            end else if (active_reg) begin
                if (!last_phase) begin
                    phase_reg <= phase_reg + 8'd1;
                end else begin
                    phase_reg <= '0;
                    if (!sclk_reg) begin
                        // Sample on the edge that drives SCLK high; data settled during the low half.
                        sclk_reg  <= 1'b1;
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_reg};
                    end else if (bit_reg == BIT_LAST) begin
                        active_reg <= 1'b0;
                    end else begin
                        sclk_reg <= 1'b0;
                        bit_reg  <= bit_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/temp_sensor_poller.sv
// Autonomous periodic poller for the temperature sensor; fan hysteresis enabled by TEMP_FAN_CTRL_EN.
module temp_sensor_poller
    import temp_poller_pkg::*;
#(
    parameter int                 CLK_DIV        = 5,
    parameter int                 SAMPLE_PERIOD  = 5_000_000,
    parameter logic signed [15:0] FAN_ON_THRESH  = 16'sd1600,
    parameter logic signed [15:0] FAN_OFF_THRESH = 16'sd1280
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start,
    output logic        temp_cs_n,
    output logic        temp_sclk,
    output logic        temp_din,
    input  logic        temp_dout,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        frame_err,
    output logic        busy,
    output logic        fan_ctrl
);

    localparam int                   TIMER_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]           DIV_LAST   = 8'(CLK_DIV - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("temp_sensor_poller: CLK_DIV out of range 2..255");
    end
    if (SAMPLE_PERIOD < 256) begin : g_bad_period
        $error("temp_sensor_poller: SAMPLE_PERIOD below 256");
    end
    if (FAN_OFF_THRESH >= FAN_ON_THRESH) begin : g_bad_thresh
        $error("temp_sensor_poller: FAN_OFF_THRESH must be below FAN_ON_THRESH");
    end

    poll_state_t           state_reg;
    logic [7:0]            wait_reg;
    logic [TIMER_W-1:0]    timer_reg;
    logic                  cs_n_reg;
    logic                  busy_reg;
    logic signed [15:0]    data_reg;
    logic                  valid_reg;
    logic                  err_reg;
    logic                  expiry;
    logic                  trigger;
    logic                  go;
    logic                  shift_done;
    logic [FRAME_BITS-1:0] shift_word;

    assign expiry  = enable && (timer_reg == TIMER_LAST);
    assign trigger = start || expiry;
    assign go      = (state_reg == ST_CS_SETUP) && (wait_reg == DIV_LAST);

    temp_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk   (clk),
        .rst_n (reset_n),
        .go    (go),
        .sdi   (temp_dout),
        .sclk  (temp_sclk),
        .done  (shift_done),
        .word  (shift_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
            timer_reg <= '0;
            cs_n_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_reg <= ST_CS_SETUP;
                        cs_n_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        wait_reg  <= '0;
                        timer_reg <= '0;
                    end else if (!enable) begin
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_CS_SETUP: begin
                    if (wait_reg == DIV_LAST) begin
                        wait_reg  <= '0;
                        state_reg <= ST_SHIFT;
                    end else begin
                        wait_reg <= wait_reg + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done) state_reg <= ST_CS_HOLD;
                end
                ST_CS_HOLD: begin
                    if (wait_reg == DIV_LAST) begin
                        // Publish on entry to DONE so the strobe lands in the DONE cycle itself.
                        wait_reg  <= '0;
                        cs_n_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                        if (frame_ok(shift_word)) begin
                            data_reg  <= sign_extend_data(shift_word);
                            valid_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else begin
                        wait_reg <= wait_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cs_n_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TEMP_FAN_CTRL_EN
    logic fan_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fan_reg <= 1'b0;
        end else if (valid_reg) begin
            if (data_reg >= FAN_ON_THRESH)       fan_reg <= 1'b1;
            else if (data_reg <= FAN_OFF_THRESH) fan_reg <= 1'b0;
        end
    end

    assign fan_ctrl = fan_reg;
`else
    assign fan_ctrl = 1'b0;
`endif

    assign temp_cs_n  = cs_n_reg;
    assign temp_din   = 1'b0;
    assign temp_data  = data_reg;
    assign temp_valid = valid_reg;
    assign frame_err  = err_reg;
    assign busy       = busy_reg;

endmodule
